// File: rtl/fifo_sync.sv
// Single-clock FIFO, DEPTH = 2**ADDRSIZE words. Standard mode gives registered rdata one cycle after an accepted read; FWFT shows the head word combinationally.
// Backpressure: writes while full and reads while empty are dropped and raise sticky overflow/underflow flags.
module fifo_sync #(
    parameter int DATASIZE   = 8,
    parameter int ADDRSIZE   = 4,
    parameter int AFULL_LVL  = 14,
    parameter int AEMPTY_LVL = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                wfull,
    output logic                walmost_full,
    output logic                rempty,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_C  = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0] AFULL_C  = (ADDRSIZE+1)'(AFULL_LVL);
    localparam logic [ADDRSIZE:0] AEMPTY_C = (ADDRSIZE+1)'(AEMPTY_LVL);

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE:0]   count_next;
    logic                we;
    logic                re;

    assign we = winc && !wfull;
    assign re = rinc && !rempty;
    assign count_next = count + (ADDRSIZE+1)'(we) - (ADDRSIZE+1)'(re);

    // Storage is deliberately left out of reset.
    always_ff @(posedge wclk) begin
        if (we)
            mem[wptr[ADDRSIZE-1:0]] <= wdata;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            wfull         <= 1'b0;
            walmost_full  <= 1'b0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            if (we)
                wptr <= wptr + 1'b1;
            if (re)
                rptr <= rptr + 1'b1;
            count         <= count_next;
            wfull         <= (count_next == DEPTH_C);
            walmost_full  <= (count_next >= AFULL_C);
            rempty        <= (count_next == '0);
            ralmost_empty <= (count_next <= AEMPTY_C);
            overflow      <= overflow  | (winc && wfull);
            underflow     <= underflow | (rinc && rempty);
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign rdata = mem[rptr[ADDRSIZE-1:0]];
        end else begin : g_std
            logic [DATASIZE-1:0] rdata_q;
            always_ff @(posedge wclk or negedge wrst_n) begin
                if (!wrst_n)
                    rdata_q <= '0;
                else if (re)
                    rdata_q <= mem[rptr[ADDRSIZE-1:0]];
            end
            assign rdata = rdata_q;
        end
    endgenerate

    // The occupancy counter must always agree with the pointer distance.
    a_count_matches_ptrs: assert property (@(posedge wclk) disable iff (!wrst_n)
        (count == (wptr - rptr)) && !(wfull && rempty));

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: one standard-mode instance and one FWFT instance on a shared clock and reset.
module tb_fifo_sync;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       a_winc = 1'b0, a_rinc = 1'b0;
    logic [7:0] a_wdata = '0, a_rdata;
    logic       a_wfull, a_walmost_full, a_rempty, a_ralmost_empty, a_overflow, a_underflow;
    logic [4:0] a_count;
    logic       b_winc = 1'b0, b_rinc = 1'b0;
    logic [7:0] b_wdata = '0, b_rdata;
    logic       b_wfull, b_walmost_full, b_rempty, b_ralmost_empty, b_overflow, b_underflow;
    logic [4:0] b_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 wclk = ~wclk;

    fifo_sync #(.DATASIZE(8), .ADDRSIZE(4), .AFULL_LVL(14), .AEMPTY_LVL(2), .FWFT(1'b0)) u_std (
        .wclk(wclk), .wrst_n(wrst_n), .winc(a_winc), .wdata(a_wdata), .rinc(a_rinc),
        .rdata(a_rdata), .wfull(a_wfull), .walmost_full(a_walmost_full), .rempty(a_rempty),
        .ralmost_empty(a_ralmost_empty), .count(a_count), .overflow(a_overflow), .underflow(a_underflow));

    fifo_sync #(.DATASIZE(8), .ADDRSIZE(4), .AFULL_LVL(14), .AEMPTY_LVL(2), .FWFT(1'b1)) u_fwft (
        .wclk(wclk), .wrst_n(wrst_n), .winc(b_winc), .wdata(b_wdata), .rinc(b_rinc),
        .rdata(b_rdata), .wfull(b_wfull), .walmost_full(b_walmost_full), .rempty(b_rempty),
        .ralmost_empty(b_ralmost_empty), .count(b_count), .overflow(b_overflow), .underflow(b_underflow));

    // Advance one edge and settle just after it; inputs change here, well before the next edge.
    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        a_winc = 0; a_rinc = 0; b_winc = 0; b_rinc = 0;
        wrst_n = 0;
        step();
        wrst_n = 1;
    endtask

    // Flag vector order: {wfull, walmost_full, rempty, ralmost_empty, overflow, underflow}
    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({a_wfull, a_walmost_full, a_rempty, a_ralmost_empty, a_overflow, a_underflow} !== 6'b001100)
            $display("FAIL reset_flags: got %b expected %b",
                {a_wfull, a_walmost_full, a_rempty, a_ralmost_empty, a_overflow, a_underflow}, 6'b001100);
        else n_pass++;
        n_checks++;
        if (a_count !== 5'd0 || a_rdata !== 8'h00)
            $display("FAIL reset_count_rdata: got %0d/%0h expected 0/0", a_count, a_rdata);
        else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            a_winc = 1; a_wdata = 8'(i);
            step();
            n_checks++;
            if (a_count !== 5'(i + 1) ||
                {a_wfull, a_walmost_full, a_rempty, a_ralmost_empty, a_overflow, a_underflow} !==
                {(i + 1 == 16), (i + 1 >= 14), 1'b0, (i + 1 <= 2), 2'b00})
                $display("FAIL fill_%0d: got count=%0d flags=%b expected count=%0d flags=%b", i, a_count,
                    {a_wfull, a_walmost_full, a_rempty, a_ralmost_empty, a_overflow, a_underflow},
                    i + 1, {(i + 1 == 16), (i + 1 >= 14), 1'b0, (i + 1 <= 2), 2'b00});
            else n_pass++;
        end
        a_wdata = 8'hFF;
        step();
        a_winc = 0;
        n_checks++;
        if (a_overflow !== 1'b1 || a_count !== 5'd16 || a_wfull !== 1'b1)
            $display("FAIL overflow: got ovf=%b count=%0d full=%b expected 1/16/1", a_overflow, a_count, a_wfull);
        else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            a_rinc = 1;
            step();
            n_checks++;
            if (a_rdata !== 8'(i) || a_count !== 5'(15 - i) ||
                {a_wfull, a_walmost_full, a_rempty, a_ralmost_empty, a_overflow, a_underflow} !==
                {1'b0, (15 - i >= 14), (i == 15), (15 - i <= 2), 2'b10})
                $display("FAIL drain_%0d: got data=%0h count=%0d flags=%b expected data=%0h count=%0d flags=%b",
                    i, a_rdata, a_count, {a_wfull, a_walmost_full, a_rempty, a_ralmost_empty, a_overflow, a_underflow},
                    i, 15 - i, {1'b0, (15 - i >= 14), (i == 15), (15 - i <= 2), 2'b10});
            else n_pass++;
        end
        step();
        a_rinc = 0;
        n_checks++;
        if (a_underflow !== 1'b1 || a_rdata !== 8'h0F || a_count !== 5'd0)
            $display("FAIL underflow: got unf=%b data=%0h count=%0d expected 1/0f/0", a_underflow, a_rdata, a_count);
        else n_pass++;
    endtask

    task automatic test_simul_empty();
        do_reset();
        a_winc = 1; a_rinc = 1; a_wdata = 8'h11;
        step();
        a_winc = 0; a_rinc = 0;
        n_checks++;
        if (a_count !== 5'd1 || a_rempty !== 1'b0 || a_rdata !== 8'h00)
            $display("FAIL simul_empty: got count=%0d empty=%b data=%0h expected 1/0/00", a_count, a_rempty, a_rdata);
        else n_pass++;
        a_rinc = 1;
        step();
        a_rinc = 0;
        n_checks++;
        if (a_rdata !== 8'h11 || a_count !== 5'd0)
            $display("FAIL simul_empty_read: got data=%0h count=%0d expected 11/0", a_rdata, a_count);
        else n_pass++;
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 16; i++) begin
            a_winc = 1; a_wdata = 8'(8'h20 + i);
            step();
        end
        a_rinc = 1; a_wdata = 8'h99;
        step();
        a_rinc = 0;
        n_checks++;
        if (a_count !== 5'd15 || a_wfull !== 1'b0 || a_rdata !== 8'h20 || a_overflow !== 1'b1)
            $display("FAIL simul_full: got count=%0d full=%b data=%0h ovf=%b expected 15/0/20/1",
                a_count, a_wfull, a_rdata, a_overflow);
        else n_pass++;
        step();
        a_winc = 0;
        n_checks++;
        if (a_count !== 5'd16 || a_wfull !== 1'b1)
            $display("FAIL simul_full_refill: got count=%0d full=%b expected 16/1", a_count, a_wfull);
        else n_pass++;
        for (int i = 1; i < 16; i++) begin
            a_rinc = 1;
            step();
        end
        step();
        a_rinc = 0;
        n_checks++;
        if (a_rdata !== 8'h99 || a_rempty !== 1'b1)
            $display("FAIL simul_full_tail: got data=%0h empty=%b expected 99/1", a_rdata, a_rempty);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a_winc = 1; a_wdata = 8'(8'h40 + i);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            a_winc = 1; a_rinc = 1; a_wdata = 8'(8'h48 + i);
            step();
            n_checks++;
            if (a_count !== 5'd8 || a_rdata !== 8'(8'h40 + i))
                $display("FAIL b2b_%0d: got count=%0d data=%0h expected 8/%0h", i, a_count, a_rdata, 8'(8'h40 + i));
            else n_pass++;
        end
        a_winc = 0; a_rinc = 0;
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] exp_d;
        int cnt = 0, wr_n = 0, rd_n = 0, budget = 0;
        bit we, re;
        do_reset();
        while (rd_n < 40 && budget < 2000) begin
            a_winc = (wr_n < 40) && ($urandom_range(0, 2) != 0);
            a_rinc = (rd_n < 40) && ($urandom_range(0, 1) != 0);
            a_wdata = 8'(8'h80 + wr_n);
            we = a_winc && (cnt != 16);
            re = a_rinc && (cnt != 0);
            step();
            budget++;
            if (re) begin
                exp_d = q.pop_front();
                rd_n++;
                n_checks++;
                if (a_rdata !== exp_d)
                    $display("FAIL wrap_data_%0d: got %0h expected %0h", rd_n, a_rdata, exp_d);
                else n_pass++;
            end
            if (we) begin
                q.push_back(8'(8'h80 + wr_n));
                wr_n++;
            end
            cnt = cnt + int'(we) - int'(re);
            n_checks++;
            if (a_count !== 5'(cnt))
                $display("FAIL wrap_count_cyc%0d: got %0d expected %0d", budget, a_count, cnt);
            else n_pass++;
        end
        a_winc = 0; a_rinc = 0;
        n_checks++;
        if (rd_n != 40)
            $display("FAIL wrap_timeout: got %0d reads expected 40", rd_n);
        else n_pass++;
    endtask

    task automatic test_fwft();
        do_reset();
        b_winc = 1; b_wdata = 8'hA5;
        step();
        b_winc = 0;
        n_checks++;
        if (b_rempty !== 1'b0 || b_rdata !== 8'hA5 || b_count !== 5'd1)
            $display("FAIL fwft_show: got empty=%b data=%0h count=%0d expected 0/a5/1", b_rempty, b_rdata, b_count);
        else n_pass++;
        b_rinc = 1;
        step();
        b_rinc = 0;
        n_checks++;
        if (b_rempty !== 1'b1 || b_count !== 5'd0 || b_underflow !== 1'b0)
            $display("FAIL fwft_pop: got empty=%b count=%0d unf=%b expected 1/0/0", b_rempty, b_count, b_underflow);
        else n_pass++;
        b_winc = 1; b_wdata = 8'h11;
        step();
        b_wdata = 8'h22;
        step();
        b_winc = 0;
        n_checks++;
        if (b_rdata !== 8'h11)
            $display("FAIL fwft_head: got %0h expected 11", b_rdata);
        else n_pass++;
        b_rinc = 1;
        step();
        b_rinc = 0;
        n_checks++;
        if (b_rdata !== 8'h22 || b_count !== 5'd1)
            $display("FAIL fwft_next: got data=%0h count=%0d expected 22/1", b_rdata, b_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            a_winc = 1; a_wdata = 8'(8'h50 + i);
            step();
        end
        a_winc = 0; a_rinc = 1;
        step();
        a_rinc = 0;
        n_checks++;
        if (a_count !== 5'd9 || a_rdata !== 8'h50)
            $display("FAIL mid_setup: got count=%0d data=%0h expected 9/50", a_count, a_rdata);
        else n_pass++;
        #3 wrst_n = 0;
        #1;
        n_checks++;
        if (a_count !== 5'd0 || a_rdata !== 8'h00 ||
            {a_wfull, a_walmost_full, a_rempty, a_ralmost_empty, a_overflow, a_underflow} !== 6'b001100)
            $display("FAIL mid_async: got count=%0d data=%0h flags=%b expected 0/00/001100", a_count, a_rdata,
                {a_wfull, a_walmost_full, a_rempty, a_ralmost_empty, a_overflow, a_underflow});
        else n_pass++;
        #2 wrst_n = 1;
        a_winc = 1; a_wdata = 8'h3C;
        step();
        a_winc = 0; a_rinc = 1;
        step();
        a_rinc = 0;
        n_checks++;
        if (a_rdata !== 8'h3C || a_count !== 5'd0)
            $display("FAIL mid_after: got data=%0h count=%0d expected 3c/0", a_rdata, a_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simul_empty();
        test_simul_full();
        test_back_to_back();
        test_wrap();
        test_fwft();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
